// File: rtl/hilo_ctrl.sv
// HI/LO result-path sequencer: serialises MULT/DIV/MFxx/MTxx requests,
// launches the mult/div units, commits their results and bounds their latency.
module hilo_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  req_op,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        busy,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_start,
  input  logic        div_done,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output logic        mf_valid,
  output logic        div_zero_exc,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [2:0] {
    IDLE, M_LAUNCH, M_WAIT, D_LAUNCH, D_WAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;

  // Strobes decoded straight from the state register; ack must answer in-cycle.
  assign ack        = req & (state == IDLE);
  assign busy       = (state != IDLE);
  assign mult_start = (state == M_LAUNCH);
  assign div_start  = (state == D_LAUNCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      hi           <= '0;
      lo           <= '0;
      mf_data      <= '0;
      mf_valid     <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      mf_valid     <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            case (req_op)
              OP_MULT: state <= M_LAUNCH;
              OP_DIV:  state <= D_LAUNCH;
              OP_MFHI: begin mf_data <= hi; mf_valid <= 1'b1; end
              OP_MFLO: begin mf_data <= lo; mf_valid <= 1'b1; end
              OP_MTHI: hi <= wdata;
              OP_MTLO: lo <= wdata;
              default: ;
            endcase
          end
        end
        // Done is not sampled here: the unit's done level may still be stale.
        M_LAUNCH: begin
          wait_cnt <= '0;
          state    <= M_WAIT;
        end
        M_WAIT: begin
          if (mult_done) begin
            hi    <= mult_hi;
            lo    <= mult_lo;
            state <= IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        D_LAUNCH: begin
          wait_cnt <= '0;
          state    <= D_WAIT;
        end
        D_WAIT: begin
          if (div_done) begin
            if (div_zero) begin
              div_zero_exc <= 1'b1;
            end else begin
              hi <= div_hi;
              lo <= div_lo;
            end
            state <= IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a behavioural 33-edge multiplier model.
module tb_hilo_ctrl;

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_RSVD = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [2:0]  req_op;
  logic [31:0] wdata;
  logic        ack, busy, mult_start, mult_done, div_start;
  logic [31:0] mult_hi, mult_lo;
  logic        div_done, div_zero;
  logic [31:0] div_hi, div_lo;
  logic [31:0] hi, lo, mf_data;
  logic        mf_valid, div_zero_exc, timeout_err;

  int vecs = 0;
  int errs = 0;

  hilo_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .wdata(wdata),
    .ack(ack), .busy(busy),
    .mult_start(mult_start), .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_done(div_done), .div_zero(div_zero),
    .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .mf_data(mf_data), .mf_valid(mf_valid),
    .div_zero_exc(div_zero_exc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier model: done rises in cycle 35 when start was in cycle 1; done is a held level.
  logic [31:0] m_a, m_b;
  logic [63:0] m_prod;
  logic [5:0]  m_cnt;
  logic        m_done;
  logic        m_stuck;

  always @(posedge clk) begin
    if (mult_start) begin
      m_prod <= $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
      m_cnt  <= 6'd33;
      m_done <= 1'b0;
    end else if (m_cnt != 6'd0) begin
      m_cnt <= m_cnt - 6'd1;
      if (m_cnt == 6'd1 && !m_stuck) m_done <= 1'b1;
    end
  end

  assign mult_hi   = m_prod[63:32];
  assign mult_lo   = m_prod[31:0];
  assign mult_done = m_done;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a request in cycle 0, checks ack, and returns in cycle 1 with req low.
  task automatic issue(input logic [2:0] op, input logic [31:0] wd);
    req    = 1'b1;
    req_op = op;
    wdata  = wd;
    #1;
    chk("ack", 64'(ack), 64'd1);
    tick();
    req = 1'b0;
  endtask

  // Full MULT from ack to cycle 36; optionally holds an MFLO request while busy.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic hold_mflo);
    int starts = 0;
    int idles  = 0;
    int acks   = 0;
    m_a = a;
    m_b = b;
    issue(OP_MULT, 32'd0);
    chk("mult_start_c1", 64'(mult_start), 64'd1);
    chk("busy_c1", 64'(busy), 64'd1);
    if (hold_mflo) begin
      req    = 1'b1;
      req_op = OP_MFLO;
    end
    for (int c = 2; c <= 35; c++) begin
      tick();
      starts += int'(mult_start);
      idles  += int'(!busy);
      acks   += int'(ack);
    end
    chk("mult_start_extra", 64'(starts), 64'd0);
    chk("busy_gap", 64'(idles), 64'd0);
    chk("ack_while_busy", 64'(acks), 64'd0);
    tick();
    chk("busy_c36", 64'(busy), 64'd0);
  endtask

  initial begin
    int idles;
    int terrs;
    reset = 1'b1; req = 1'b0; req_op = 3'd0; wdata = 32'd0;
    div_done = 1'b0; div_zero = 1'b0; div_hi = 32'd0; div_lo = 32'd0;
    m_a = 32'd0; m_b = 32'd0; m_prod = 64'd0; m_cnt = 6'd0; m_done = 1'b0; m_stuck = 1'b0;
    #1 reset = 1'b0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_mf_data", 64'(mf_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", {59'd0, mult_start, div_start, mf_valid, div_zero_exc, timeout_err}, 64'd0);
    reset = 1'b1;
    tick();

    // MULT 7 * -3
    run_mult(32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("mul1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mul1_lo", 64'(lo), 64'hFFFF_FFEB);

    // MTHI then MFHI
    issue(OP_MTHI, 32'h1234_5678);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_lo", 64'(lo), 64'hFFFF_FFEB);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(OP_MFHI, 32'd0);
    chk("mfhi_valid", 64'(mf_valid), 64'd1);
    chk("mfhi_data", 64'(mf_data), 64'h1234_5678);
    tick();
    chk("mfhi_valid_drop", 64'(mf_valid), 64'd0);

    // MFLO interlocked behind MULT 0x10000 * 0x10000
    run_mult(32'h0001_0000, 32'h0001_0000, 1'b1);
    chk("mflo_ack_idle", 64'(ack), 64'd1);
    chk("mul2_hi", 64'(hi), 64'd1);
    chk("mul2_lo", 64'(lo), 64'd0);
    tick();
    req = 1'b0;
    chk("mflo_valid", 64'(mf_valid), 64'd1);
    chk("mflo_data", 64'(mf_data), 64'd0);
    chk("mflo_hi", 64'(hi), 64'd1);

    // DIV with divide-by-zero
    issue(OP_DIV, 32'd0);
    chk("div_start_c1", 64'(div_start), 64'd1);
    chk("div_busy_c1", 64'(busy), 64'd1);
    tick();
    chk("div_start_c2", 64'(div_start), 64'd0);
    div_done = 1'b1; div_zero = 1'b1; div_hi = 32'hAAAA; div_lo = 32'hBBBB;
    tick();
    chk("dz_exc", 64'(div_zero_exc), 64'd1);
    chk("dz_busy", 64'(busy), 64'd0);
    chk("dz_hilo", {hi, lo}, {32'd1, 32'd0});
    div_done = 1'b0; div_zero = 1'b0;
    tick();
    chk("dz_exc_drop", 64'(div_zero_exc), 64'd0);

    // DIV with stale done held through D_LAUNCH
    div_done = 1'b1; div_hi = 32'd5; div_lo = 32'd9;
    issue(OP_DIV, 32'd0);
    div_done = 1'b0;
    tick();
    chk("div_stale_busy", 64'(busy), 64'd1);
    chk("div_stale_hi", 64'(hi), 64'd1);
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    chk("div_hilo", {hi, lo}, {32'd5, 32'd9});
    chk("div_busy_end", 64'(busy), 64'd0);
    chk("div_no_exc", 64'(div_zero_exc), 64'd0);

    // Stuck multiplier: stale done from the last MULT is high during M_LAUNCH
    m_stuck = 1'b1;
    m_a = 32'd3; m_b = 32'd3;
    issue(OP_MULT, 32'd0);
    idles = 0; terrs = 0;
    for (int c = 2; c <= 66; c++) begin
      tick();
      idles += int'(!busy);
      terrs += int'(timeout_err);
    end
    chk("to_early_idle", 64'(idles), 64'd0);
    chk("to_early_err", 64'(terrs), 64'd0);
    tick();
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_hilo", {hi, lo}, {32'd5, 32'd9});
    tick();
    chk("to_err_drop", 64'(timeout_err), 64'd0);
    m_stuck = 1'b0;

    // Reserved opcode
    issue(OP_RSVD, 32'hDEAD_BEEF);
    chk("rsvd_busy", 64'(busy), 64'd0);
    chk("rsvd_hilo", {hi, lo}, {32'd5, 32'd9});
    chk("rsvd_mf_valid", 64'(mf_valid), 64'd0);

    // Reset in M_WAIT cycle 10, then a clean MULT -6 * 7
    m_a = 32'hFFFF_FFFA; m_b = 32'd7;
    issue(OP_MULT, 32'd0);
    for (int c = 2; c <= 11; c++) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_start", 64'(mult_start), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    run_mult(32'hFFFF_FFFA, 32'd7, 1'b0);
    chk("mul3_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mul3_lo", 64'(lo), 64'hFFFF_FFD6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
